// File: rtl/toom_5.sv
// Pipelined 1024x1024 unsigned multiplier built on Toom-Cook 5-way splitting.
// Stage 1 registers nine pointwise products; stage 2 interpolates and recomposes.
module toom_5 (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1023:0] D_in,
    input  logic [1023:0] E_in,
    output logic [2047:0] mul_value
);

    localparam int LIMB = 205;
    localparam int EW   = 216;
    localparam int PW   = 432;
    localparam int IW   = 448;
    localparam int OW   = 2048;

    // 2-adic inverses: exact division by an odd constant is a multiply mod 2^IW
    localparam logic [IW-1:0] INV3  = {{111{4'hA}}, 4'hB};
    localparam logic [IW-1:0] INV5  = {{111{4'hC}}, 4'hD};
    localparam logic [IW-1:0] INV7  = {1'b0, {148{3'b110}}, 3'b111};
    localparam logic [IW-1:0] INV15 = {{111{4'hE}}, 4'hF};

    function automatic logic [8:0][EW-1:0] eval_points(input logic [4:0][LIMB-1:0] l);
        logic signed [EW-1:0] x0, x1, x2, x3, x4;
        logic signed [EW-1:0] ev1, od1, ev2, od2, ev3, od3, p4;
        logic [8:0][EW-1:0]   v;
        x0  = $signed({11'b0, l[0]});
        x1  = $signed({11'b0, l[1]});
        x2  = $signed({11'b0, l[2]});
        x3  = $signed({11'b0, l[3]});
        x4  = $signed({11'b0, l[4]});
        ev1 = x0 + x2 + x4;
        od1 = x1 + x3;
        ev2 = x0 + (x2 <<< 2) + (x4 <<< 4);
        od2 = (x1 <<< 1) + (x3 <<< 3);
        ev3 = x0 + x2 * 216'sd9 + x4 * 216'sd81;
        od3 = x1 * 216'sd3 + x3 * 216'sd27;
        p4  = x0 + (x1 <<< 2) + (x2 <<< 4) + (x3 <<< 6) + (x4 <<< 8);
        // point order: 0, 1, -1, 2, -2, 3, -3, 4, inf
        v[0] = x0;
        v[1] = ev1 + od1;
        v[2] = ev1 - od1;
        v[3] = ev2 + od2;
        v[4] = ev2 - od2;
        v[5] = ev3 + od3;
        v[6] = ev3 - od3;
        v[7] = p4;
        v[8] = x4;
        return v;
    endfunction

    function automatic logic signed [PW-1:0] mul_s(input logic signed [EW-1:0] x,
                                                   input logic signed [EW-1:0] y);
        logic signed [PW-1:0] xe, ye;
        xe = {{(PW-EW){x[EW-1]}}, x};
        ye = {{(PW-EW){y[EW-1]}}, y};
        return xe * ye;
    endfunction

    function automatic logic signed [IW-1:0] sx(input logic [PW-1:0] v);
        return $signed({{(IW-PW){v[PW-1]}}, v});
    endfunction

    function automatic logic signed [IW-1:0] exact_div(input logic signed [IW-1:0] x,
                                                       input logic [IW-1:0] inv);
        return $signed($unsigned(x) * inv);
    endfunction

    function automatic logic signed [IW-1:0] asr(input logic signed [IW-1:0] x, input int sh);
        return x >>> sh;
    endfunction

    logic [4:0][LIMB-1:0] a_limb, b_limb;
    logic [8:0][EW-1:0]   a_eval, b_eval;
    logic [8:0][PW-1:0]   r_d, r_q;
    logic [OW-1:0]        mul_value_d, mul_value_q;

    logic signed [IW-1:0] w0, w1, wm1, w2, wm2, w3, wm3, w4, winf;
    logic signed [IW-1:0] ev_1, ev_2, ev_3, o1, o4, o9, o16;
    logic signed [IW-1:0] e1, e4, e9, d1, d2;
    logic signed [IW-1:0] g01, g12, g23, h012, h123;
    logic signed [IW-1:0] c0, c1, c2, c3, c4, c5, c6, c7, c8;
    logic [8:0][IW-1:0]   coef;

    assign a_limb = {1'b0, D_in};
    assign b_limb = {1'b0, E_in};

    always_comb begin
        a_eval = eval_points(a_limb);
        b_eval = eval_points(b_limb);
        for (int i = 0; i < 9; i++) begin
            r_d[i] = mul_s(a_eval[i], b_eval[i]);
        end
    end

    // Even/odd split of the symmetric points, then Newton divided differences in x^2
    always_comb begin
        w0   = sx(r_q[0]);
        w1   = sx(r_q[1]);
        wm1  = sx(r_q[2]);
        w2   = sx(r_q[3]);
        wm2  = sx(r_q[4]);
        w3   = sx(r_q[5]);
        wm3  = sx(r_q[6]);
        w4   = sx(r_q[7]);
        winf = sx(r_q[8]);

        c0   = w0;
        c8   = winf;
        ev_1 = asr(w1 + wm1, 1);
        ev_2 = asr(w2 + wm2, 1);
        ev_3 = asr(w3 + wm3, 1);
        o1   = asr(w1 - wm1, 1);
        o4   = asr(w2 - wm2, 2);
        o9   = exact_div(asr(w3 - wm3, 1), INV3);

        e1   = ev_1 - c0 - c8;
        e4   = asr(ev_2 - c0 - (c8 <<< 8), 2);
        e9   = exact_div(exact_div(ev_3 - c0 - c8 * 448'sd6561, INV3), INV3);
        d1   = exact_div(e4 - e1, INV3);
        d2   = exact_div(e9 - e4, INV5);
        c6   = asr(d2 - d1, 3);
        c4   = d1 - c6 * 448'sd5;
        c2   = e1 - c4 - c6;

        // with the even coefficients known, the point 4 yields the odd polynomial at x^2=16
        o16  = asr(w4 - c0 - (c2 <<< 4) - (c4 <<< 8) - (c6 <<< 12) - (c8 <<< 16), 2);
        g01  = exact_div(o4 - o1, INV3);
        g12  = exact_div(o9 - o4, INV5);
        g23  = exact_div(o16 - o9, INV7);
        h012 = asr(g12 - g01, 3);
        h123 = exact_div(asr(g23 - g12, 2), INV3);
        c7   = exact_div(h123 - h012, INV15);
        c5   = h012 - c7 * 448'sd14;
        c3   = g01 - c5 * 448'sd5 - c7 * 448'sd21;
        c1   = o1 - c3 - c5 - c7;

        coef = {c8, c7, c6, c5, c4, c3, c2, c1, c0};
        mul_value_d = '0;
        for (int j = 0; j < 9; j++) begin
            mul_value_d = mul_value_d + ({{(OW-IW){1'b0}}, coef[j]} << (LIMB * j));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q         <= '0;
            mul_value_q <= '0;
        end else begin
            r_q         <= r_d;
            mul_value_q <= mul_value_d;
        end
    end

    assign mul_value = mul_value_q;

endmodule

// File: tb/tb_toom_5.sv
// Directed and streamed checks of toom_5 against a wide-integer reference product.
module tb_toom_5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1023:0] D_in;
    logic [1023:0] E_in;
    logic [2047:0] mul_value;

    int compared   = 0;
    int mismatched = 0;

    logic [2047:0] exp_hist [1000];

    always #5 clk = ~clk;

    toom_5 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .D_in      (D_in),
        .E_in      (E_in),
        .mul_value (mul_value)
    );

    function automatic logic [1023:0] rand_op();
        logic [1023:0] v;
        for (int i = 0; i < 32; i++) begin
            v[i*32 +: 32] = $urandom;
        end
        return v;
    endfunction

    function automatic logic [2047:0] model(input logic [1023:0] d, input logic [1023:0] e);
        logic [2047:0] de, ee;
        de = {1024'b0, d};
        ee = {1024'b0, e};
        return de * ee;
    endfunction

    task automatic checkOutput(input string tag, input logic [2047:0] got,
                               input logic [2047:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("[TB] FAIL %s: got hi=%h lo=%h, want hi=%h lo=%h",
                     tag, got[2047:1984], got[127:0], want[2047:1984], want[127:0]);
        end
    endtask

    task automatic applyStimulus(input logic [1023:0] d, input logic [1023:0] e);
        @(negedge clk);
        D_in = d;
        E_in = e;
    endtask

    task automatic runDirected(input string tag, input logic [1023:0] d,
                               input logic [1023:0] e, input logic [2047:0] want);
        applyStimulus(d, e);
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput(tag, mul_value, want);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] stopped by watchdog");
    end

    initial begin
        logic [1023:0] d, e, x, ones, p1023, p205, p820, m205;
        logic [1023:0] post [3];
        logic [2047:0] want;

        ones  = '1;
        p1023 = 1024'b1 << 1023;
        p205  = 1024'b1 << 205;
        p820  = 1024'b1 << 820;
        m205  = p205 - 1024'd1;

        rst_n = 1'b0;
        D_in  = rand_op();
        E_in  = rand_op();
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #2;
            checkOutput("reset_hold", mul_value, '0);
            D_in = rand_op();
            E_in = rand_op();
        end

        d = rand_op();
        e = rand_op();
        @(negedge clk);
        rst_n = 1'b1;
        D_in  = d;
        E_in  = e;
        @(posedge clk);
        #1;
        checkOutput("release_edge1", mul_value, '0);
        applyStimulus(rand_op(), rand_op());
        @(posedge clk);
        #1;
        checkOutput("release_first", mul_value, model(d, e));

        d = 1024'd123456781234567812345678876543211234567812345678;
        e = 1024'd876543218765432187654321123456781234567812345678;
        runDirected("directed_dec", d, e, model(d, e));

        runDirected("zero_x_ones", '0, ones, '0);
        x = rand_op();
        runDirected("one_x_X", 1024'd1, x, {1024'b0, x});
        runDirected("msb_sq", p1023, p1023, 2048'b1 << 2046);
        runDirected("ones_sq", ones, ones,
                    {{1023{1'b1}}, 1'b0, {1023{1'b0}}, 1'b1});
        runDirected("limb_shift", p205, p820, 2048'b1 << 1025);
        want = (2048'b1 << 410) - (2048'b1 << 206) + 2048'd1;
        runDirected("limb_max_sq", m205, m205, want);
        runDirected("ones_x_one", ones, 1024'd1, {1024'b0, ones});
        d = rand_op();
        e = rand_op();
        runDirected("random_pair", d, e, model(d, e));

        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                checkOutput("stream", mul_value, exp_hist[i-2]);
            end
            d = rand_op();
            e = rand_op();
            D_in = d;
            E_in = e;
            exp_hist[i] = model(d, e);
        end
        @(negedge clk);
        checkOutput("stream_tail0", mul_value, exp_hist[998]);
        @(negedge clk);
        checkOutput("stream_tail1", mul_value, exp_hist[999]);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(rand_op(), rand_op());
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("reset_async", mul_value, '0);
        D_in = rand_op();
        E_in = rand_op();
        @(posedge clk);
        #1;
        checkOutput("reset_mid_held", mul_value, '0);

        for (int i = 0; i < 3; i++) begin
            post[i] = rand_op();
        end
        @(negedge clk);
        rst_n = 1'b1;
        D_in  = post[0];
        E_in  = post[1];
        @(posedge clk);
        #1;
        checkOutput("post_release_edge1", mul_value, '0);
        applyStimulus(post[1], post[2]);
        @(posedge clk);
        #1;
        checkOutput("post_release_p0", mul_value, model(post[0], post[1]));
        applyStimulus(post[2], post[0]);
        @(posedge clk);
        #1;
        checkOutput("post_release_p1", mul_value, model(post[1], post[2]));
        @(posedge clk);
        #1;
        checkOutput("post_release_p2", mul_value, model(post[2], post[0]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
